// File: rtl/regfile_pkg.sv
// Shared constants and encodings for the register-file write-port arbiter.
package regfile_pkg;

    localparam int unsigned REG_IDX_WIDTH = 4;
    localparam int unsigned REG_COUNT     = 2 ** REG_IDX_WIDTH;

    // Arbiter FSM states
    localparam logic [0:0] ARB   = 1'b0;
    localparam logic [0:0] CLEAR = 1'b1;

    // Requester select encoding
    localparam logic [0:0] SEL_A = 1'b0;
    localparam logic [0:0] SEL_B = 1'b1;

endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter2.sv
// Two-input round-robin grant logic with a registered priority pointer.
module rr_arbiter2 (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic req_a,
    input  logic req_b,
    output logic gnt_a_c,
    output logic gnt_b_c,
    output logic gnt_sel_c
);
    import regfile_pkg::*;

    logic [0:0] ptr;

    // A lone requester always wins; on contention the pointer side wins.
    always_comb begin
        gnt_a_c   = 1'b0;
        gnt_b_c   = 1'b0;
        gnt_sel_c = SEL_A;
        if (en) begin
            if (req_a && (!req_b || (ptr == SEL_A))) begin
                gnt_a_c   = 1'b1;
                gnt_sel_c = SEL_A;
            end else if (req_b) begin
                gnt_b_c   = 1'b1;
                gnt_sel_c = SEL_B;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= SEL_A;
        end else if (gnt_a_c) begin
            ptr <= SEL_B;
        end else if (gnt_b_c) begin
            ptr <= SEL_A;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between the ALU and load writeback paths,
// with a sequencer that zeroes every register one per cycle on request.
module regfile_write_arbiter #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned REG_IDX_WIDTH = regfile_pkg::REG_IDX_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     a_valid,
    input  logic [REG_IDX_WIDTH-1:0] a_idx,
    input  logic [DATA_WIDTH-1:0]    a_data,
    output logic                     a_ready,
    input  logic                     b_valid,
    input  logic [REG_IDX_WIDTH-1:0] b_idx,
    input  logic [DATA_WIDTH-1:0]    b_data,
    output logic                     b_ready,
    input  logic                     clr_req,
    output logic                     wr_en,
    output logic [REG_IDX_WIDTH-1:0] wr_idx,
    output logic [DATA_WIDTH-1:0]    wr_data,
    output logic                     busy,
    output logic                     clr_done
);
    import regfile_pkg::*;

    localparam int unsigned        CNT_W    = REG_IDX_WIDTH + 1;
    localparam logic [CNT_W-1:0]   LAST_IDX = CNT_W'((2 ** REG_IDX_WIDTH) - 1);

    logic [0:0]               state, state_nxt;
    logic [CNT_W-1:0]         cnt, cnt_nxt;
    logic                     wr_en_nxt, busy_nxt, clr_done_nxt;
    logic [REG_IDX_WIDTH-1:0] wr_idx_nxt;
    logic [DATA_WIDTH-1:0]    wr_data_nxt;
    logic                     arb_en, gnt_a, gnt_b, gnt_sel;

    // A clear request blocks handshakes in the cycle it arrives.
    assign arb_en = (state == ARB) && !clr_req;

    rr_arbiter2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .en        (arb_en),
        .req_a     (a_valid),
        .req_b     (b_valid),
        .gnt_a_c   (gnt_a),
        .gnt_b_c   (gnt_b),
        .gnt_sel_c (gnt_sel)
    );

    assign a_ready = gnt_a;
    assign b_ready = gnt_b;

    // Next state and next registered outputs; cnt tracks the index on wr_idx.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        wr_en_nxt    = 1'b0;
        wr_idx_nxt   = wr_idx;
        wr_data_nxt  = wr_data;
        busy_nxt     = 1'b0;
        clr_done_nxt = 1'b0;
        case (state)
            ARB: begin
                if (clr_req) begin
                    state_nxt   = CLEAR;
                    cnt_nxt     = '0;
                    wr_en_nxt   = 1'b1;
                    wr_idx_nxt  = '0;
                    wr_data_nxt = '0;
                    busy_nxt    = 1'b1;
                end else if (gnt_a || gnt_b) begin
                    wr_en_nxt   = 1'b1;
                    wr_idx_nxt  = (gnt_sel == SEL_A) ? a_idx  : b_idx;
                    wr_data_nxt = (gnt_sel == SEL_A) ? a_data : b_data;
                end
            end
            CLEAR: begin
                if (cnt == LAST_IDX) begin
                    state_nxt = ARB;
                end else begin
                    cnt_nxt      = cnt + CNT_W'(1);
                    wr_en_nxt    = 1'b1;
                    wr_idx_nxt   = cnt_nxt[REG_IDX_WIDTH-1:0];
                    wr_data_nxt  = '0;
                    busy_nxt     = 1'b1;
                    clr_done_nxt = (cnt_nxt == LAST_IDX);
                end
            end
            default: state_nxt = ARB;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ARB;
            cnt      <= '0;
            wr_en    <= 1'b0;
            wr_idx   <= '0;
            wr_data  <= '0;
            busy     <= 1'b0;
            clr_done <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            wr_en    <= wr_en_nxt;
            wr_idx   <= wr_idx_nxt;
            wr_data  <= wr_data_nxt;
            busy     <= busy_nxt;
            clr_done <= clr_done_nxt;
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: expected writes are queued when
// stimulus is applied and retired when the write port shows them.
module tb_regfile_write_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_valid = 1'b0, b_valid = 1'b0, clr_req = 1'b0;
    logic [3:0]  a_idx = 4'd0, b_idx = 4'd0;
    logic [31:0] a_data = 32'd0, b_data = 32'd0;
    logic        a_ready, b_ready, wr_en, busy, clr_done;
    logic [3:0]  wr_idx;
    logic [31:0] wr_data;

    regfile_write_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .a_valid  (a_valid),
        .a_idx    (a_idx),
        .a_data   (a_data),
        .a_ready  (a_ready),
        .b_valid  (b_valid),
        .b_idx    (b_idx),
        .b_data   (b_data),
        .b_ready  (b_ready),
        .clr_req  (clr_req),
        .wr_en    (wr_en),
        .wr_idx   (wr_idx),
        .wr_data  (wr_data),
        .busy     (busy),
        .clr_done (clr_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [3:0]  idx;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          cd_count = 0;
    logic [31:0] rf [16];

    // bench model state
    logic        m_clearing = 1'b0;
    int          m_cidx = 0;
    logic        m_ptr_b = 1'b0;
    logic        m_wr_exp = 1'b0;
    logic [3:0]  m_last_idx = 4'd0;
    logic [31:0] m_last_data = 32'd0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Retire expected writes as the port shows them; a regfile image follows the writes.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            check("wr_en_missing", 64'(wr_en), 64'd1);
            void'(exp_q.pop_front());
        end
        if (clr_done === 1'b1) cd_count++;
        if (wr_en === 1'b1) begin
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                check("wr_idx", 64'(wr_idx), 64'(exp_q[0].idx));
                check("wr_data", 64'(wr_data), 64'(exp_q[0].data));
                void'(exp_q.pop_front());
            end else begin
                check("wr_en_spurious", 64'(wr_en), 64'd0);
            end
            rf[wr_idx] = wr_data;
        end
    end

    task automatic push(input logic [3:0] idx, input logic [31:0] data);
        exp_t e;
        e.cyc = cyc + 1;
        e.idx = idx;
        e.data = data;
        exp_q.push_back(e);
        m_wr_exp    = 1'b1;
        m_last_idx  = idx;
        m_last_data = data;
    endtask

    task automatic step(input logic r, input logic av, input logic [3:0] ai, input logic [31:0] ad,
                        input logic bv, input logic [3:0] bi, input logic [31:0] bd, input logic cr);
        logic ga, gb;
        @(posedge clk);
        #1;
        rst = r; a_valid = av; a_idx = ai; a_data = ad;
        b_valid = bv; b_idx = bi; b_data = bd; clr_req = cr;
        @(negedge clk);
        if (r) begin
            m_clearing  = 1'b0;
            m_cidx      = 0;
            m_ptr_b     = 1'b0;
            m_wr_exp    = 1'b0;
            m_last_idx  = 4'd0;
            m_last_data = 32'd0;
            return;
        end
        check("busy", 64'(busy), 64'(m_clearing));
        check("clr_done", 64'(clr_done), 64'(m_clearing && m_cidx == 15));
        check("both_ready", 64'(a_ready & b_ready), 64'd0);
        if (!m_wr_exp) begin
            check("wr_en_idle", 64'(wr_en), 64'd0);
            check("wr_idx_hold", 64'(wr_idx), 64'(m_last_idx));
            check("wr_data_hold", 64'(wr_data), 64'(m_last_data));
        end
        m_wr_exp = 1'b0;
        ga = 1'b0;
        gb = 1'b0;
        if (m_clearing) begin
            if (m_cidx == 15) begin
                m_clearing = 1'b0;
            end else begin
                m_cidx++;
                push(4'(m_cidx), 32'd0);
            end
        end else if (cr) begin
            m_clearing = 1'b1;
            m_cidx = 0;
            push(4'd0, 32'd0);
        end else begin
            ga = av && (!bv || !m_ptr_b);
            gb = bv && !ga;
            if (ga) begin
                push(ai, ad);
                m_ptr_b = 1'b1;
            end else if (gb) begin
                push(bi, bd);
                m_ptr_b = 1'b0;
            end
        end
        check("a_ready", 64'(a_ready), 64'(ga));
        check("b_ready", 64'(b_ready), 64'(gb));
    endtask

    task automatic idle(input logic cr);
        step(1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, cr);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0);
    endtask

    initial begin
        int cd_before;
        do_reset();
        do_reset();
        idle(1'b0);

        // A only
        step(1'b0, 1'b1, 4'd3, 32'h1234, 1'b0, 4'd0, 32'd0, 1'b0);
        idle(1'b0);
        idle(1'b0);

        // both valid from reset: A,B,A,B
        do_reset();
        for (int i = 0; i < 4; i++)
            step(1'b0, 1'b1, 4'd1, 32'hA, 1'b1, 4'd2, 32'hB, 1'b0);
        idle(1'b0);

        // same-index collision, pointer back at A
        step(1'b0, 1'b1, 4'd5, 32'h11, 1'b1, 4'd5, 32'h22, 1'b0);
        step(1'b0, 1'b0, 4'd0, 32'd0, 1'b1, 4'd5, 32'h22, 1'b0);
        idle(1'b0);
        idle(1'b0);
        check("rf5_last_write", 64'(rf[5]), 64'h22);

        // clear with A pending in the request cycle
        cd_before = cd_count;
        step(1'b0, 1'b1, 4'd7, 32'h77, 1'b0, 4'd0, 32'd0, 1'b1);
        for (int i = 0; i < 17; i++)
            step(1'b0, 1'b1, 4'd7, 32'h77, 1'b0, 4'd0, 32'd0, 1'b0);
        idle(1'b0);
        idle(1'b0);
        check("clr_done_count1", 64'(cd_count - cd_before), 64'd1);
        check("rf7_after_clear", 64'(rf[7]), 64'h77);
        check("rf15_cleared", 64'(rf[15]), 64'd0);

        // second clear request mid-sequence is ignored
        cd_before = cd_count;
        idle(1'b1);
        for (int i = 0; i < 17; i++)
            idle(i == 6);
        idle(1'b0);
        check("clr_done_count2", 64'(cd_count - cd_before), 64'd1);

        // reset during clear cycle 9 aborts without clr_done
        cd_before = cd_count;
        idle(1'b1);
        for (int i = 0; i < 8; i++)
            idle(1'b0);
        do_reset();
        idle(1'b0);
        step(1'b0, 1'b1, 4'd9, 32'h99, 1'b1, 4'd10, 32'hAA, 1'b0);
        idle(1'b0);
        idle(1'b0);
        check("clr_done_after_abort", 64'(cd_count - cd_before), 64'd0);
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port between two writeback requesters: requester A (ALU result) and requester B (memory load).
- Round-robin arbitration with a valid/ready handshake per requester.
- Contains a clear sequencer that zeroes all 16 registers, one per cycle, on request.
- Sits between the execute/memory stages and the register file write inputs (data, destination index, enable).

Parameters:
- DATA_WIDTH, 32, width of write data.
- REG_IDX_WIDTH, 4, register index width; register count = 2**REG_IDX_WIDTH = 16.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- a_valid  input  1  requester A has a write pending
- a_idx  input  REG_IDX_WIDTH  requester A destination register
- a_data  input  DATA_WIDTH  requester A write data
- a_ready  output  1  requester A accepted this cycle (combinational)
- b_valid  input  1  requester B has a write pending
- b_idx  input  REG_IDX_WIDTH  requester B destination register
- b_data  input  DATA_WIDTH  requester B write data
- b_ready  output  1  requester B accepted this cycle (combinational)
- clr_req  input  1  single-cycle pulse requesting a full register clear
- wr_en  output  1  register file write enable (registered)
- wr_idx  output  REG_IDX_WIDTH  register file write index (registered)
- wr_data  output  DATA_WIDTH  register file write data (registered)
- busy  output  1  high while the clear sequence runs
- clr_done  output  1  one-cycle pulse in the cycle the final clear write is driven

Behaviour:
- Reset (rst=1 at a posedge):
  - state=ARB; wr_en=0, wr_idx=0, wr_data=0; busy=0; clr_done=0; clear counter=0.
  - Priority pointer set to favour A.
  - Reset mid-clear aborts the clear with no clr_done.
- State ARB:
  - Handshake completes when valid && ready.
  - At most one handshake per cycle.
  - Only one valid: that requester gets ready=1, regardless of the pointer.
  - Both valid: the pointer side gets ready=1. After each grant the pointer moves to the other requester.
  - ready never asserts without the matching valid.
  - Grant latency: the handshake in cycle N drives wr_en=1 with the granted idx/data in cycle N+1. The register file captures at the end of N+1.
  - No handshake in cycle N: wr_en=0 in N+1; wr_idx/wr_data hold their previous values.
  - Same idx from both requesters: writes are serialized. The later-granted write wins in the register file. No merging or dropping.
- Clear priority:
  - clr_req=1 in ARB forces a_ready=b_ready=0 in that cycle.
  - Next state is CLEAR, counter=0.
  - Any handshake already registered (wr_en high in that cycle) still completes normally.
- State CLEAR:
  - busy=1; a_ready=b_ready=0.
  - Each cycle drives wr_en=1, wr_idx=counter, wr_data=0, then increments the counter.
  - 16 consecutive write cycles, idx 0..15 in order.
  - clr_done=1 in the same cycle as the idx=15 write; next state ARB.
  - clr_req during CLEAR is ignored; the sequence is not restarted.
  - Priority pointer is unchanged by a clear.
  - Registered output timing: the first clear write appears in the cycle after clr_req; busy rises in that same cycle.
- Arithmetic: counter is REG_IDX_WIDTH+1 bits internally or a terminal-compare on 15; no wrap-around into a second pass.

Decomposition:
- Shared package regfile_pkg:
  - constants REG_IDX_WIDTH=4 and REG_COUNT=16;
  - arbiter state enum {ARB, CLEAR};
  - requester select encoding {SEL_A, SEL_B}.
- One natural sub-module: rr_arbiter2 (two-input round-robin grant logic plus pointer register), reusable for the read-port sharing planned later.
- The clear sequencer stays inline.

Test Plan:
- Reset, then A-only: a_valid=1, a_idx=3, a_data=0x1234 in cycle 1 → a_ready=1 in cycle 1; wr_en=1, wr_idx=3, wr_data=0x1234 in cycle 2; wr_en=0 in cycle 3.
- Both valid continuously, A idx=1 data=0xA, B idx=2 data=0xB, from reset → grants alternate A,B,A,B; wr_idx sequence 1,2,1,2; never both ready in one cycle.
- Same-index collision: A idx=5 data=0x11 and B idx=5 data=0x22 together, pointer=A → writes 0x11 then 0x22 on consecutive cycles; a regfile model holds 0x22.
- Clear: clr_req pulse with a_valid=1 in the same cycle → a_ready=0; next 16 cycles wr_en=1, wr_idx 0..15, wr_data=0, busy=1; clr_done only with idx=15; A accepted in the first cycle back in ARB.
- Clear with a second clr_req at clear cycle 7 → sequence still ends after exactly 16 writes, one clr_done.
- rst=1 during clear cycle 9 → next cycle wr_en=0, busy=0, no clr_done; ARB resumes with A-favoured pointer.
